// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// 32-cycle shift-add multiply and restoring shift-subtract divide on operand magnitudes.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic [1:0]       op_q;
   logic             neg_a_q, neg_b_q, divz_q;
   logic [WIDTH-1:0] acc_q, q_q, opb_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sum, shifted, diff;
   logic [WIDTH-1:0] acc_d, q_d;
   logic             neg_res;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

   // Operand magnitudes; op_i[0]=0 selects the signed variants.
   always_comb begin
      a_neg = ~op_i[0] & a_i[WIDTH-1];
      b_neg = ~op_i[0] & b_i[WIDTH-1];
      a_mag = a_neg ? -a_i : a_i;
      b_mag = b_neg ? -b_i : b_i;
   end

   // One iteration: acc holds the upper product half or the partial remainder,
   // q holds the shifting multiplier or the dividend/quotient.
   always_comb begin
      sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, opb_q} : '0);
      shifted = {acc_q, q_q[WIDTH-1]};
      diff    = shifted - {1'b0, opb_q};
      acc_d   = acc_q;
      q_d     = q_q;
      if (!op_q[1]) begin
         acc_d = sum[WIDTH:1];
         q_d   = {sum[0], q_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_d = diff[WIDTH-1:0];
         q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = shifted[WIDTH-1:0];
         q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   // Final sign fix-up applied to the last iteration's output at the commit edge.
   always_comb begin
      neg_res = ~op_q[0] & (neg_a_q ^ neg_b_q);
      prod    = {acc_d, q_d};
      if (neg_res) prod = -prod;
      quo = neg_res ? -q_d : q_d;
      if (divz_q) quo = '1;
      rem = (~op_q[0] & neg_a_q) ? -acc_d : acc_d;
      res_hi = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
      res_lo = op_q[1] ? quo : prod[WIDTH-1:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         divz_q  <= 1'b0;
         acc_q   <= '0;
         q_q     <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  state_q <= StCalc;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  op_q    <= op_i;
                  neg_a_q <= a_neg;
                  neg_b_q <= b_neg;
                  divz_q  <= (b_i == '0);
                  acc_q   <= '0;
                  q_q     <= a_mag;
                  opb_q   <= b_mag;
               end else begin
                  state_q <= StIdle;
                  if (mthi_i) hi_q <= wdata_i;
                  if (mtlo_i) lo_q <= wdata_i;
               end
            end
            StCalc: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = '0;
   logic [31:0] a_i = '0, b_i = '0;
   logic        mthi_i = 1'b0, mtlo_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int n_vec = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(start_i),
      .op_i   (op_i),
      .a_i    (a_i),
      .b_i    (b_i),
      .mthi_i (mthi_i),
      .mtlo_i (mtlo_i),
      .wdata_i(wdata_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'd0: return 64'(sa * sb);
         2'd1: return ua * ub;
         default: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (op == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   // Issue one op from #1 after an edge; return at #1 after the commit edge (DONE cycle).
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output logic [31:0] rhi, output logic [31:0] rlo,
                        output int nbusy, output bit held_ok, output logic rdone);
      logic [31:0] hi0, lo0;
      hi0 = hi_o;
      lo0 = lo_o;
      held_ok = 1'b1;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b; mthi_i = 1'b0; mtlo_i = 1'b0;
      @(posedge clk_i); #1;
      start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
      nbusy = 0;
      while (busy_o === 1'b1 && nbusy < 100) begin
         nbusy++;
         if (hi_o !== hi0 || lo_o !== lo0 || done_o !== 1'b0) held_ok = 1'b0;
         if (noise) begin
            start_i = 1'($urandom); mthi_i = 1'($urandom); mtlo_i = 1'($urandom);
            wdata_i = $urandom; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
         end
         @(posedge clk_i); #1;
      end
      start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
      rhi = hi_o;
      rlo = lo_o;
      rdone = done_o;
   endtask

   task automatic test_reset();
      n_vec++;
      if ({busy_o, done_o, hi_o, lo_o} !== 66'd0) begin
         n_err++;
         $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all zero",
                  busy_o, done_o, hi_o, lo_o);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
      logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
      logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
      logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'd7, 32'd0};
      logic [31:0] elo [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'h80000000};
      logic [31:0] rhi, rlo;
      int nb;
      bit held;
      logic rd;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], as[i], bs[i], 1'b0, rhi, rlo, nb, held, rd);
         n_vec++;
         if (rhi !== ehi[i] || rlo !== elo[i]) begin
            n_err++;
            $display("FAIL directed_%0d: got hi=%h lo=%h, want hi=%h lo=%h",
                     i, rhi, rlo, ehi[i], elo[i]);
         end
         n_vec++;
         if (nb !== 32 || rd !== 1'b1 || !held) begin
            n_err++;
            $display("FAIL directed_timing_%0d: got busy_cycles=%0d done=%b held=%0d, want 32 1 1",
                     i, nb, rd, held);
         end
         @(posedge clk_i); #1;
         n_vec++;
         if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL directed_done_width_%0d: got done=%b busy=%b, want 0 0",
                     i, done_o, busy_o);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, rhi, rlo;
      logic [63:0] exp;
      int nb, sel;
      bit held;
      logic rd;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) b = $urandom_range(1, 15);
         else if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (sel == 3) b = -32'($urandom_range(1, 15));
         exp = model(op, a, b);
         do_op(op, a, b, 1'($urandom), rhi, rlo, nb, held, rd);
         n_vec++;
         if ({rhi, rlo} !== exp || nb !== 32 || rd !== 1'b1 || !held) begin
            n_err++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h busy=%0d done=%b held=%0d, want hi=%h lo=%h busy=32 done=1 held=1",
                     i, op, a, b, rhi, rlo, nb, rd, held, exp[63:32], exp[31:0]);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rhi, rlo;
      logic [63:0] exp;
      int nb;
      bit held;
      logic rd;
      do_op(2'd0, 32'h12345678, 32'hFEDCBA98, 1'b1, rhi, rlo, nb, held, rd);
      exp = model(2'd0, 32'h12345678, 32'hFEDCBA98);
      n_vec++;
      if ({rhi, rlo} !== exp || rd !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_first: got %h done=%b, want %h done=1", {rhi, rlo}, rd, exp);
      end
      do_op(2'd3, 32'd1000, 32'd7, 1'b0, rhi, rlo, nb, held, rd);
      n_vec++;
      if (rhi !== 32'd6 || rlo !== 32'd142 || nb !== 32 || rd !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_second: got hi=%h lo=%h busy=%0d done=%b, want 6 8e 32 1",
                  rhi, rlo, nb, rd);
      end
      @(posedge clk_i); #1;
      n_vec++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
      end
   endtask

   task automatic test_moves();
      logic [31:0] r, h0, l0;
      int n;
      mtlo_i = 1'b1; wdata_i = 32'h12345678;
      @(posedge clk_i); #1;
      mtlo_i = 1'b0;
      n_vec++;
      if (lo_o !== 32'h12345678) begin
         n_err++;
         $display("FAIL mtlo_idle: got lo=%h, want 12345678", lo_o);
      end
      r = $urandom;
      mthi_i = 1'b1; wdata_i = r;
      @(posedge clk_i); #1;
      mthi_i = 1'b0;
      n_vec++;
      if (hi_o !== r || lo_o !== 32'h12345678) begin
         n_err++;
         $display("FAIL mthi_idle: got hi=%h lo=%h, want hi=%h lo=12345678", hi_o, lo_o, r);
      end
      r = $urandom;
      mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = r;
      @(posedge clk_i); #1;
      mthi_i = 1'b0; mtlo_i = 1'b0;
      n_vec++;
      if (hi_o !== r || lo_o !== r) begin
         n_err++;
         $display("FAIL mthi_mtlo_both: got hi=%h lo=%h, want %h", hi_o, lo_o, r);
      end
      h0 = hi_o; l0 = lo_o;
      start_i = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd5;
      mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = ~r;
      @(posedge clk_i); #1;
      start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
      n_vec++;
      if (hi_o !== h0 || lo_o !== l0 || busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL move_with_start: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=1",
                  hi_o, lo_o, busy_o, h0, l0);
      end
      n = 0;
      while (busy_o === 1'b1 && n < 100) begin n++; @(posedge clk_i); #1; end
      n_vec++;
      if (hi_o !== 32'd0 || lo_o !== 32'd15 || done_o !== 1'b1) begin
         n_err++;
         $display("FAIL move_start_result: got hi=%h lo=%h done=%b, want 0 f 1",
                  hi_o, lo_o, done_o);
      end
      r = $urandom;
      mthi_i = 1'b1; wdata_i = r;
      @(posedge clk_i); #1;
      mthi_i = 1'b0;
      n_vec++;
      if (hi_o !== r || lo_o !== 32'd15) begin
         n_err++;
         $display("FAIL mthi_in_done: got hi=%h lo=%h, want hi=%h lo=f", hi_o, lo_o, r);
      end
   endtask

   task automatic test_reset_abort();
      bit bad;
      int n;
      mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hAAAAAAAA;
      @(posedge clk_i); #1;
      mthi_i = 1'b0; mtlo_i = 1'b0;
      start_i = 1'b1; op_i = 2'd2; a_i = $urandom; b_i = $urandom_range(1, 1000);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      n_vec++;
      if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort_immediate: got hi=%h lo=%h busy=%b done=%b, want 0 0 0 0",
                  hi_o, lo_o, busy_o, done_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (done_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL reset_abort_quiet: got activity after reset, want none");
      end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      start_i = 1'b1; op_i = 2'd1; a_i = 32'd6; b_i = 32'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL first_start_after_reset: got busy=%b, want 1", busy_o);
      end
      n = 0;
      while (busy_o === 1'b1 && n < 100) begin n++; @(posedge clk_i); #1; end
      n_vec++;
      if (hi_o !== 32'd0 || lo_o !== 32'd42 || n !== 32) begin
         n_err++;
         $display("FAIL first_op_result: got hi=%h lo=%h busy=%0d, want 0 2a 32", hi_o, lo_o, n);
      end
   endtask

   initial begin
      #1 rst_i = 1'b1;
      #2;
      test_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      test_directed();
      test_random();
      test_back_to_back();
      test_moves();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
